// File: rtl/axi_lite_slave_if.sv
// AXI4-Lite slave that turns AXI-Lite reads and writes into simple register-access strobes.
// The read and write paths each have their own FSM and allow one outstanding transaction.
module axi_lite_slave_if #(
    parameter logic [31:0] C_ADDR_MASK  = 32'h00007FFF,
    parameter int unsigned C_RD_TIMEOUT = 256,
    parameter logic [31:0] C_ERR_DATA   = 32'hBADFEED0
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    output logic [31:0] wr_addr,
    output logic [3:0]  wr_be,
    output logic [31:0] wr_data,
    output logic        wr_en,
    input  logic        wr_busy,
    output logic [31:0] rd_addr,
    output logic [3:0]  rd_be,
    output logic        rd_en,
    input  logic [31:0] rd_data,
    input  logic        rd_data_valid
);

    // state   | meaning
    // W_IDLE  | collecting AW and W, in either order
    // W_ISSUE | wr_en pulse
    // W_WAIT  | waiting for wr_busy to drop
    // W_RESP  | BVALID held until BREADY
    // R_IDLE  | accepting AR
    // R_ISSUE | rd_en pulse, rd_data_valid already honoured
    // R_WAIT  | waiting for rd_data_valid or timeout
    // R_RESP  | RVALID held until RREADY
    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} rd_state_t;

    localparam logic [15:0] C_RD_TO = 16'(C_RD_TIMEOUT);

    wr_state_t   r_wr_state, w_wr_next;
    rd_state_t   r_rd_state, w_rd_next;
    logic        r_live;
    logic        r_aw_held, r_w_held;
    logic [31:0] r_wr_addr, r_wr_data, r_rd_addr, r_rdata;
    logic [3:0]  r_wr_be;
    logic [1:0]  r_rresp;
    logic [15:0] r_rd_cnt;
    logic        w_awready, w_wready, w_arready;
    logic        w_aw_hs, w_w_hs, w_ar_hs;
    logic        w_rd_take, w_rd_timeout;
    logic        w_unused;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // Readies stay low until the first clock edge after reset release.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) r_live <= 1'b0;
        else                r_live <= 1'b1;
    end

    assign w_awready = r_live && (r_wr_state == W_IDLE) && !r_aw_held;
    assign w_wready  = r_live && (r_wr_state == W_IDLE) && !r_w_held;
    assign w_aw_hs   = S_AXI_AWVALID && w_awready;
    assign w_w_hs    = S_AXI_WVALID && w_wready;

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) w_wr_next = W_ISSUE;
            W_ISSUE: w_wr_next = W_WAIT;
            W_WAIT:  if (!wr_busy) w_wr_next = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_wr_next = W_IDLE;
            default: w_wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_wr_state <= W_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_be    <= '0;
        end else begin
            r_wr_state <= w_wr_next;
            if (w_aw_hs) begin
                r_wr_addr <= (S_AXI_AWADDR & C_ADDR_MASK) >> 2;
                r_aw_held <= 1'b1;
            end
            if (w_w_hs) begin
                r_wr_data <= S_AXI_WDATA;
                r_wr_be   <= S_AXI_WSTRB;
                r_w_held  <= 1'b1;
            end
            if (w_wr_next == W_ISSUE) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    assign w_arready    = r_live && (r_rd_state == R_IDLE);
    assign w_ar_hs      = S_AXI_ARVALID && w_arready;
    assign w_rd_take    = rd_data_valid && ((r_rd_state == R_ISSUE) || (r_rd_state == R_WAIT));
    assign w_rd_timeout = (r_rd_state == R_WAIT) && (r_rd_cnt == 16'd0);

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_ar_hs) w_rd_next = R_ISSUE;
            R_ISSUE: w_rd_next = w_rd_take ? R_RESP : R_WAIT;
            R_WAIT:  if (w_rd_take || w_rd_timeout) w_rd_next = R_RESP;
            R_RESP:  if (S_AXI_RREADY) w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
    end

    // Timeout counter is loaded during R_ISSUE so R_WAIT lasts C_RD_TIMEOUT+1 cycles.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rd_state <= R_IDLE;
            r_rd_addr  <= '0;
            r_rd_cnt   <= '0;
            r_rdata    <= '0;
            r_rresp    <= 2'b00;
        end else begin
            r_rd_state <= w_rd_next;
            if (w_ar_hs) r_rd_addr <= (S_AXI_ARADDR & C_ADDR_MASK) >> 2;
            if (r_rd_state == R_ISSUE)
                r_rd_cnt <= C_RD_TO;
            else if ((r_rd_state == R_WAIT) && (r_rd_cnt != 16'd0))
                r_rd_cnt <= r_rd_cnt - 16'd1;
            if (w_rd_take) begin
                r_rdata <= rd_data;
                r_rresp <= 2'b00;
            end else if (w_rd_timeout) begin
                r_rdata <= C_ERR_DATA;
                r_rresp <= 2'b10;
            end
        end
    end

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BVALID  = (r_wr_state == W_RESP);
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_RVALID  = (r_rd_state == R_RESP);
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign wr_en         = (r_wr_state == W_ISSUE);
    assign wr_addr       = r_wr_addr;
    assign wr_data       = r_wr_data;
    assign wr_be         = r_wr_be;
    assign rd_en         = (r_rd_state == R_ISSUE);
    assign rd_addr       = r_rd_addr;
    assign rd_be         = 4'hF;

endmodule

// File: tb/tb_axi_lite_slave_if.sv
// Self-checking bench for axi_lite_slave_if: directed and randomized AXI-Lite traffic
// checked against a transaction-level model of addresses, data and response latencies.
module tb_axi_lite_slave_if;

    localparam int          TO   = 8;
    localparam logic [31:0] MASK = 32'h00007FFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
    logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
    logic [3:0]  wr_be, rd_be;
    logic        wr_en, wr_busy, rd_en, rd_data_valid;

    always #5 clk = ~clk;

    axi_lite_slave_if #(.C_RD_TIMEOUT(TO)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_en(wr_en), .wr_busy(wr_busy),
        .rd_addr(rd_addr), .rd_be(rd_be), .rd_en(rd_en),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: cycle c is the clock period observed at its falling edge with cyc == c.
    int aw_hs_cyc = 0, w_hs_cyc = 0, ar_hs_cyc = 0;
    int wr_en_cnt = 0, wr_en_cyc = 0, rd_en_cnt = 0, rd_en_cyc = 0;
    int b_rise = 0, b_first_cyc = 0, b_hs_cnt = 0;
    int r_rise = 0, r_first_cyc = 0, r_hs_cnt = 0;
    int stab_err = 0;
    logic [31:0] m_waddr = '0, m_wdata = '0, m_raddr = '0, m_rdata = '0, p_rdata = '0;
    logic [3:0]  m_wbe = '0, m_rbe = '0;
    logic [1:0]  m_bresp = '0, m_rresp = '0, p_bresp = '0, p_rresp = '0;
    logic        p_bv = 1'b0, p_bhs = 1'b0, p_rv = 1'b0, p_rhs = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_bv <= 1'b0;
            p_rv <= 1'b0;
        end else begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_hs_cyc <= cyc;
            if (S_AXI_WVALID && S_AXI_WREADY)   w_hs_cyc  <= cyc;
            if (S_AXI_ARVALID && S_AXI_ARREADY) ar_hs_cyc <= cyc;
            if (wr_en) begin
                wr_en_cnt <= wr_en_cnt + 1; wr_en_cyc <= cyc;
                m_waddr <= wr_addr; m_wdata <= wr_data; m_wbe <= wr_be;
            end
            if (rd_en) begin
                rd_en_cnt <= rd_en_cnt + 1; rd_en_cyc <= cyc;
                m_raddr <= rd_addr; m_rbe <= rd_be;
            end
            if (S_AXI_BVALID && !p_bv) begin b_rise <= b_rise + 1; b_first_cyc <= cyc; end
            if (S_AXI_RVALID && !p_rv) begin r_rise <= r_rise + 1; r_first_cyc <= cyc; end
            if ((p_bv && !p_bhs && (!S_AXI_BVALID || S_AXI_BRESP !== p_bresp)) ||
                (p_rv && !p_rhs && (!S_AXI_RVALID || S_AXI_RDATA !== p_rdata || S_AXI_RRESP !== p_rresp)))
                stab_err <= stab_err + 1;
            if (S_AXI_BVALID && S_AXI_BREADY) begin b_hs_cnt <= b_hs_cnt + 1; m_bresp <= S_AXI_BRESP; end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                r_hs_cnt <= r_hs_cnt + 1; m_rdata <= S_AXI_RDATA; m_rresp <= S_AXI_RRESP;
            end
            p_bv <= S_AXI_BVALID; p_bhs <= S_AXI_BVALID && S_AXI_BREADY; p_bresp <= S_AXI_BRESP;
            p_rv <= S_AXI_RVALID; p_rhs <= S_AXI_RVALID && S_AXI_RREADY;
            p_rdata <= S_AXI_RDATA; p_rresp <= S_AXI_RRESP;
        end
    end

    logic wr_active = 1'b0;
    logic leak = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: note which address/data handshakes complete, then drop their VALIDs.
    task automatic tick();
        logic aw_ok, w_ok, ar_ok;
        @(negedge clk);
        aw_ok = S_AXI_AWVALID && S_AXI_AWREADY;
        w_ok  = S_AXI_WVALID && S_AXI_WREADY;
        ar_ok = S_AXI_ARVALID && S_AXI_ARREADY;
        if (wr_active && (S_AXI_AWREADY || S_AXI_WREADY)) leak = 1'b1;
        @(posedge clk); #1;
        if (aw_ok) S_AXI_AWVALID = 1'b0;
        if (w_ok)  S_AXI_WVALID  = 1'b0;
        if (ar_ok) S_AXI_ARVALID = 1'b0;
    endtask

    // w_lead > 0: W leads AW by w_lead cycles; < 0: AW leads W.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, input int busy_n, input int bready_n);
        int en0, b0, hs, n, exp_b;
        en0 = wr_en_cnt; b0 = b_hs_cnt;
        S_AXI_BREADY = (bready_n == 0);
        wr_busy = (busy_n > 0);
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        if (w_lead >= 0) begin
            S_AXI_WVALID = 1'b1;
            repeat (w_lead) tick();
            S_AXI_AWVALID = 1'b1;
        end else begin
            S_AXI_AWVALID = 1'b1;
            repeat (-w_lead) tick();
            S_AXI_WVALID = 1'b1;
        end
        n = 0;
        while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 40) begin tick(); n++; end
        hs = (aw_hs_cyc > w_hs_cyc) ? aw_hs_cyc : w_hs_cyc;
        wr_active = 1'b1; leak = 1'b0;
        n = 0;
        while (wr_en_cnt == en0 && n < 20) begin tick(); n++; end
        exp_b = hs + 3;
        if (busy_n > 0) begin
            repeat (busy_n) tick();
            wr_busy = 1'b0;
            exp_b = cyc + 1;
        end
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin tick(); n++; end
        repeat (bready_n) tick();
        S_AXI_BREADY = 1'b1;
        n = 0;
        while (b_hs_cnt == b0 && n < 20) begin tick(); n++; end
        wr_active = 1'b0;
        chk("wr_done",   32'(b_hs_cnt - b0), 32'd1);
        chk("wr_en_once", 32'(wr_en_cnt - en0), 32'd1);
        chk("wr_en_cyc", 32'(wr_en_cyc), 32'(hs + 1));
        chk("wr_addr",   m_waddr, (addr & MASK) >> 2);
        chk("wr_data",   m_wdata, data);
        chk("wr_be",     32'(m_wbe), 32'(strb));
        chk("b_latency", 32'(b_first_cyc), 32'(exp_b));
        chk("bresp",     32'(m_bresp), 32'd0);
        chk("wr_ready_while_busy", 32'(leak), 32'd0);
    endtask

    // rdv_at >= 0: rd_data_valid that many cycles after the rd_en cycle; < 0: never (timeout).
    task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                           input int rdv_at, input int rready_n);
        int en0, r0, hs, n, exp_r;
        logic [31:0] exp_d;
        logic [1:0]  exp_resp;
        en0 = rd_en_cnt; r0 = r_hs_cnt;
        S_AXI_RREADY = (rready_n == 0);
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        n = 0;
        while (S_AXI_ARVALID && n < 40) begin tick(); n++; end
        hs = ar_hs_cyc;
        if (rdv_at >= 0) begin
            repeat (rdv_at) tick();
            rd_data = data; rd_data_valid = 1'b1;
            exp_r = cyc + 1;
            tick();
            rd_data_valid = 1'b0; rd_data = $urandom;
            exp_d = data; exp_resp = 2'b00;
        end else begin
            exp_r = hs + 2 + TO + 1;
            exp_d = 32'hBADFEED0; exp_resp = 2'b10;
        end
        n = 0;
        while (!S_AXI_RVALID && n < 40) begin tick(); n++; end
        repeat (rready_n) tick();
        S_AXI_RREADY = 1'b1;
        n = 0;
        while (r_hs_cnt == r0 && n < 20) begin tick(); n++; end
        chk("rd_done",    32'(r_hs_cnt - r0), 32'd1);
        chk("rd_en_once", 32'(rd_en_cnt - en0), 32'd1);
        chk("rd_en_cyc",  32'(rd_en_cyc), 32'(hs + 1));
        chk("rd_addr",    m_raddr, (addr & MASK) >> 2);
        chk("rd_be",      32'(m_rbe), 32'hF);
        chk("r_latency",  32'(r_first_cyc), 32'(exp_r));
        chk("rdata",      m_rdata, exp_d);
        chk("rresp",      32'(m_rresp), 32'(exp_resp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, n, b0, r0, c_wen, c_ren, c_brise, c_rrise;
        logic [31:0] a1, a2, d1, d2;
        logic [3:0]  s1;

        rst_n = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        wr_busy = 1'b0; rd_data = '0; rd_data_valid = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
        chk("rst_valid", 32'({S_AXI_BVALID, S_AXI_RVALID, wr_en, rd_en}), 32'd0);
        chk("rst_resp",  32'({S_AXI_BRESP, S_AXI_RRESP}), 32'd0);
        chk("rst_rdata", S_AXI_RDATA, 32'd0);
        chk("rst_waddr", wr_addr, 32'd0);
        chk("rst_wdata", wr_data, 32'd0);
        chk("rst_raddr", rd_addr, 32'd0);
        chk("rst_wbe",   32'(wr_be), 32'd0);
        chk("rst_rbe",   32'(rd_be), 32'hF);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
        @(posedge clk); #1;
        chk("ready_after_release", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'h7);

        // Single write, AW and W together
        do_write(32'h0000_1234, 32'hA5A5_0001, 4'hF, 0, 0, 0);
        chk("wr_addr_held", wr_addr, 32'h48D);

        // W three cycles ahead of AW, busy 5 cycles, BREADY held off 4 cycles
        do_write($urandom, $urandom, 4'h5, 3, 5, 4);

        // Read with data two cycles after rd_en and RREADY back-pressure
        do_read(32'hFFFF_8010, 32'hDEAD_BEEF, 2, 3);
        chk("rd_addr_word", rd_addr, 32'h4);

        // Timeout read, stray rd_data_valid while idle, then a normal read
        do_read($urandom, 32'h0, -1, 1);
        rd_data = 32'h1111_2222; rd_data_valid = 1'b1;
        tick(); tick();
        rd_data_valid = 1'b0;
        chk("idle_rdv_ignored", 32'(S_AXI_RVALID), 32'd0);
        do_read($urandom, $urandom, 0, 0);

        // Concurrent AR and AW/W in the same cycle
        a1 = $urandom; a2 = $urandom; d1 = $urandom; d2 = $urandom; s1 = 4'($urandom_range(0, 15));
        b0 = b_hs_cnt; r0 = r_hs_cnt;
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1; wr_busy = 1'b0;
        S_AXI_AWADDR = a1; S_AXI_WDATA = d1; S_AXI_WSTRB = s1; S_AXI_ARADDR = a2;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        tick();
        hs = ar_hs_cyc;
        rd_data = d2; rd_data_valid = 1'b1;
        tick();
        rd_data_valid = 1'b0;
        n = 0;
        while ((b_hs_cnt == b0 || r_hs_cnt == r0) && n < 30) begin tick(); n++; end
        chk("cc_aw_same_cycle", 32'(aw_hs_cyc), 32'(hs));
        chk("cc_wr_en_cyc", 32'(wr_en_cyc), 32'(hs + 1));
        chk("cc_rd_en_cyc", 32'(rd_en_cyc), 32'(hs + 1));
        chk("cc_wr_addr", m_waddr, (a1 & MASK) >> 2);
        chk("cc_wr_data", m_wdata, d1);
        chk("cc_wr_be",   32'(m_wbe), 32'(s1));
        chk("cc_rd_addr", m_raddr, (a2 & MASK) >> 2);
        chk("cc_rdata",   m_rdata, d2);
        chk("cc_b_lat",   32'(b_first_cyc), 32'(hs + 3));
        chk("cc_r_lat",   32'(r_first_cyc), 32'(hs + 2));

        // Reset while the write sits in W_WAIT and the read in R_WAIT
        wr_busy = 1'b1;
        S_AXI_AWADDR = $urandom; S_AXI_WDATA = $urandom; S_AXI_ARADDR = $urandom;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        tick(); tick(); tick();
        c_wen = wr_en_cnt; c_ren = rd_en_cnt; c_brise = b_rise; c_rrise = r_rise;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'({S_AXI_BVALID, S_AXI_RVALID, wr_en, rd_en}), 32'd0);
        chk("mid_rst_ready", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
        chk("mid_rst_waddr", wr_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; wr_busy = 1'b0;
        repeat (12) tick();
        chk("abort_no_strobe", 32'({wr_en_cnt - c_wen, rd_en_cnt - c_ren}), 32'd0);
        chk("abort_no_resp",   32'({b_rise - c_brise, r_rise - c_rrise}), 32'd0);
        do_write($urandom, $urandom, 4'($urandom_range(0, 15)), 0, 1, 0);
        do_read($urandom, $urandom, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 12; i++) begin
            do_write($urandom, $urandom, 4'($urandom_range(0, 15)),
                     int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)));
            do_read($urandom, $urandom,
                    ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 2)));
        end

        chk("valid_stable", 32'(stab_err), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
